// File: rtl/f5_ctrl.sv
// F5 buffer controller: sequences one frame of F5 RAM writes, then a paced 16 x N_POS readout to F6.
// Optional sticky protocol-error flag `err` is built when F5_CTRL_ERR_EN is defined.
module f5_ctrl #(
  parameter int unsigned N_POS  = 25,
  parameter int unsigned RD_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       c5_valid,
  output logic       c5_ready,
  output logic       f5_wr_en,
  output logic [4:0] f5_waddr,
  output logic [4:0] f5_raddr,
  output logic [3:0] f5_sel,
  input  logic       f6_ready,
  output logic       f6_valid,
  output logic       f6_last,
  output logic       busy,
  output logic       done
`ifdef F5_CTRL_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_t;

  localparam logic [4:0] LAST_POS = 5'(N_POS - 1);
  localparam logic [3:0] LAST_SEL = 4'hF;

  state_t            r_state;
  state_t            w_next;
  logic [4:0]        r_wcnt;
  logic [4:0]        r_pos;
  logic [3:0]        r_sel;
  logic [RD_LAT-1:0] r_vpipe;
  logic [RD_LAT-1:0] r_lpipe;

  logic w_issue;
  logic w_pos_last;
  logic w_issue_last;
  logic w_wr_last;

  assign w_pos_last   = (r_pos == LAST_POS);
  assign w_issue_last = w_issue && w_pos_last && (r_sel == LAST_SEL);
  assign w_wr_last    = f5_wr_en && (r_wcnt == LAST_POS);

  always_comb begin
    w_next   = r_state;
    c5_ready = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_WRITE;
      end
      S_WRITE: begin
        c5_ready = 1'b1;
        if (c5_valid && (r_wcnt == LAST_POS)) w_next = S_READ;
      end
      S_READ: begin
        w_issue = f6_ready;
        if (w_issue && w_pos_last && (r_sel == LAST_SEL)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_lpipe[RD_LAT-1]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign f5_wr_en = c5_ready & c5_valid;
  assign f5_waddr = r_wcnt;
  assign f5_raddr = r_pos;
  assign f5_sel   = r_sel;
  assign f6_valid = r_vpipe[RD_LAT-1];
  assign f6_last  = r_lpipe[RD_LAT-1];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DRAIN) && r_lpipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_pos   <= '0;
      r_sel   <= '0;
      r_vpipe <= '0;
      r_lpipe <= '0;
    end else begin
      r_state <= w_next;
      if (f5_wr_en) r_wcnt <= w_wr_last ? '0 : r_wcnt + 5'd1;
      // Counters wrap to 0/0 after the final issue, so each frame starts at word 0.
      if (w_issue) begin
        if (w_pos_last) begin
          r_pos <= '0;
          r_sel <= r_sel + 4'd1;
        end else begin
          r_pos <= r_pos + 5'd1;
        end
      end
      r_vpipe <= RD_LAT'({r_vpipe, w_issue});
      r_lpipe <= RD_LAT'({r_lpipe, w_issue_last});
    end
  end

`ifdef F5_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((c5_valid && (r_state != S_WRITE)) || (start && busy)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_f5_ctrl.sv
// Self-checking bench for f5_ctrl: randomized write/read pacing against a queue-based frame model,
// plus a second instance at N_POS=1, RD_LAT=1.
module tb_f5_ctrl;
  localparam int unsigned NP = 25;
  localparam int unsigned RL = 3;
  localparam int unsigned NW = 16 * NP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, c5_valid, f6_ready;
  logic       c5_ready, f5_wr_en, f6_valid, f6_last, busy, done;
  logic [4:0] f5_waddr, f5_raddr;
  logic [3:0] f5_sel;

  logic       b_rst, b_start, b_c5_valid, b_f6_ready;
  logic       b_c5_ready, b_f5_wr_en, b_f6_valid, b_f6_last, b_busy, b_done;
  logic [4:0] b_f5_waddr, b_f5_raddr;
  logic [3:0] b_f5_sel;
`ifdef F5_CTRL_ERR_EN
  logic err, b_err;
`endif

  int checks = 0;
  int errors = 0;

  f5_ctrl #(.N_POS(NP), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .c5_valid(c5_valid), .c5_ready(c5_ready),
    .f5_wr_en(f5_wr_en), .f5_waddr(f5_waddr), .f5_raddr(f5_raddr), .f5_sel(f5_sel),
    .f6_ready(f6_ready), .f6_valid(f6_valid), .f6_last(f6_last), .busy(busy), .done(done)
`ifdef F5_CTRL_ERR_EN
    , .err(err)
`endif
  );

  f5_ctrl #(.N_POS(1), .RD_LAT(1)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .c5_valid(b_c5_valid), .c5_ready(b_c5_ready),
    .f5_wr_en(b_f5_wr_en), .f5_waddr(b_f5_waddr), .f5_raddr(b_f5_raddr), .f5_sel(b_f5_sel),
    .f6_ready(b_f6_ready), .f6_valid(b_f6_valid), .f6_last(b_f6_last), .busy(b_busy), .done(b_done)
`ifdef F5_CTRL_ERR_EN
    , .err(b_err)
`endif
  );

  function automatic logic [19:0] outs();
    return {busy, c5_ready, f5_wr_en, f5_waddr, f5_raddr, f5_sel, f6_valid, f6_last, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; c5_valid = 1'b0; f6_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    step();
    rst = 1'b0; start = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_over_start: busy got %b expected 0", busy);
    end
    step();
  endtask

  task automatic test_write(input int unsigned pct);
    int unsigned n = 0;
    int unsigned guard = 0;
    start = 1'b1; c5_valid = 1'b0; f6_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || c5_ready !== 1'b0) begin
      errors++; $display("FAIL write_idle: busy/ready got %b%b expected 00", busy, c5_ready);
    end
    step();
    start = 1'b0;
    while (n < NP && guard < 1000) begin
      c5_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      checks++;
      if (c5_ready !== 1'b1 || f5_wr_en !== c5_valid || f5_waddr !== 5'(n)) begin
        errors++;
        $display("FAIL write_beat: ready/wr_en/waddr got %b/%b/%0d expected 1/%b/%0d",
                 c5_ready, f5_wr_en, f5_waddr, c5_valid, n);
      end
      step();
      if (c5_valid) n++;
      guard++;
    end
    c5_valid = 1'b0;
    checks++;
    if (n < NP) begin
      errors++; $display("FAIL write_timeout: writes got %0d expected %0d", n, NP);
    end
    @(negedge clk);
    checks++;
    if (c5_ready !== 1'b0 || f5_wr_en !== 1'b0 || busy !== 1'b1 || f6_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_end: ready/wr_en/busy/valid got %b%b%b%b expected 0010",
               c5_ready, f5_wr_en, busy, f6_valid);
    end
    step();
  endtask

  // mode 0: ready always 1; mode 1: ready toggles 1,0; mode 2: random ready plus a stray start.
  task automatic test_read(input int mode, input int unsigned exp_len);
    int unsigned k = 0;
    int unsigned guard = 0;
    int unsigned q_t[$];
    int unsigned q_k[$];
    bit fin = 1'b0;
    logic exp_v, exp_l;
    while (!fin && guard < 3000) begin
      case (mode)
        0:       f6_ready = 1'b1;
        1:       f6_ready = (guard % 2 == 0);
        default: f6_ready = 1'($urandom_range(1));
      endcase
      start = (mode == 2 && guard == 37);
      exp_v = (q_t.size() > 0) && (q_t[0] + RL == guard);
      exp_l = exp_v && (q_k[0] == NW - 1);
      @(negedge clk);
      checks++;
      if (f6_valid !== exp_v || f6_last !== exp_l || done !== exp_l || c5_ready !== 1'b0) begin
        errors++;
        $display("FAIL read_out m%0d c%0d: valid/last/done/ready got %b%b%b%b expected %b%b%b0",
                 mode, guard, f6_valid, f6_last, done, c5_ready, exp_v, exp_l, exp_l);
      end
      if (k < NW) begin
        checks++;
        if (f5_raddr !== 5'(k % NP) || f5_sel !== 4'(k / NP)) begin
          errors++;
          $display("FAIL read_addr m%0d word %0d: sel/raddr got %0d/%0d expected %0d/%0d",
                   mode, k, f5_sel, f5_raddr, k / NP, k % NP);
        end
      end
      if (f6_ready && k < NW) begin
        q_t.push_back(guard);
        q_k.push_back(k);
        k++;
      end
      if (exp_v) begin
        void'(q_t.pop_front());
        void'(q_k.pop_front());
        if (exp_l) fin = 1'b1;
      end
      step();
      guard++;
    end
    start = 1'b0; f6_ready = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL read_timeout m%0d: done got 0 expected 1", mode);
    end else if (exp_len != 0 && guard != exp_len) begin
      errors++; $display("FAIL read_len m%0d: cycles got %0d expected %0d", mode, guard, exp_len);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || f6_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle m%0d: busy/done/valid got %b%b%b expected 000", mode, busy, done, f6_valid);
    end
    step();
  endtask

  task automatic test_rst_midframe();
    test_write(100);
    f6_ready = 1'b1;
    for (int unsigned i = 0; i < 7 * NP + 3; i++) begin
      @(negedge clk);
      checks++;
      if (f5_raddr !== 5'(i % NP) || f5_sel !== 4'(i / NP)) begin
        errors++;
        $display("FAIL abort_addr word %0d: sel/raddr got %0d/%0d expected %0d/%0d",
                 i, f5_sel, f5_raddr, i / NP, i % NP);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (f5_sel !== 4'd7) begin
      errors++; $display("FAIL abort_sel: sel got %0d expected 7", f5_sel);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; f6_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL abort_outputs: got %h expected 0", outs());
    end
    for (int unsigned i = 0; i < RL + 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (f6_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet %0d: valid/done/busy got %b%b%b expected 000", i, f6_valid, done, busy);
      end
    end
    step();
    test_write(60);
    test_read(0, NW + RL);
  endtask

  task automatic test_npos1();
    logic exp_v;
    b_start = 1'b1;
    step();
    b_start = 1'b0; b_c5_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (b_c5_ready !== 1'b1 || b_f5_wr_en !== 1'b1 || b_f5_waddr !== 5'd0) begin
      errors++;
      $display("FAIL n1_write: ready/wr_en/waddr got %b/%b/%0d expected 1/1/0", b_c5_ready, b_f5_wr_en, b_f5_waddr);
    end
    step();
    b_c5_valid = 1'b0; b_f6_ready = 1'b1;
    for (int unsigned i = 0; i < 18; i++) begin
      exp_v = (i >= 1 && i <= 16);
      @(negedge clk);
      if (i < 16) begin
        checks++;
        if (b_f5_raddr !== 5'd0 || b_f5_sel !== 4'(i) || b_c5_ready !== 1'b0) begin
          errors++;
          $display("FAIL n1_addr %0d: sel/raddr/ready got %0d/%0d/%b expected %0d/0/0", i, b_f5_sel, b_f5_raddr, b_c5_ready, i);
        end
      end
      checks++;
      if (b_f6_valid !== exp_v || b_f6_last !== (i == 16) || b_done !== (i == 16) || b_busy !== (i <= 16)) begin
        errors++;
        $display("FAIL n1_out %0d: valid/last/done/busy got %b%b%b%b expected %b%b%b%b",
                 i, b_f6_valid, b_f6_last, b_done, b_busy, exp_v, (i == 16), (i == 16), (i <= 16));
      end
      step();
    end
    b_f6_ready = 1'b0;
  endtask

`ifdef F5_CTRL_ERR_EN
  task automatic test_err();
    int unsigned guard = 0;
    bit seen = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_reset: err got %b expected 0", err);
    end
    step();
    test_write(100);
    f6_ready = 1'b1; c5_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (f5_wr_en !== 1'b0) begin
      errors++; $display("FAIL err_no_write: wr_en got %b expected 0", f5_wr_en);
    end
    step();
    c5_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_set: err got %b expected 1", err);
    end
    while (!seen && guard < 1000) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        checks++;
        if (err !== 1'b1) begin
          errors++; $display("FAIL err_sticky: err got %b expected 1", err);
        end
      end
      step();
      guard++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL err_timeout: done got 0 expected 1");
    end
    f6_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; c5_valid = 1'b0; f6_ready = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_c5_valid = 1'b0; b_f6_ready = 1'b0;
    step();
    step();
    b_rst = 1'b0;
    test_reset();
    test_write(100);
    test_read(0, NW + RL);
    test_write(50);
    test_read(1, 2 * (NW - 1) + 1 + RL);
    test_write(70);
    test_read(2, 0);
    test_rst_midframe();
    test_npos1();
`ifdef F5_CTRL_ERR_EN
    test_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
